// File: rtl/keypad_pkg.sv
// Shared keypad/display constants: strobe encodings, matrix geometry, Snake key indices.
// Helpers here are pure combinational functions used by the scanner and its debouncer.
package keypad_pkg;

  localparam int KEY_IDX_W = 4;
  localparam int NUM_COLS  = 4;
  localparam int NUM_ROWS  = 4;
  localparam int NUM_KEYS  = NUM_COLS * NUM_ROWS;

  // Same active-low one-hot rotation as the display mux anode drive.
  localparam logic [NUM_COLS-1:0] COL_STROBE_0 = 4'b1110;
  localparam logic [NUM_COLS-1:0] COL_STROBE_1 = 4'b1101;
  localparam logic [NUM_COLS-1:0] COL_STROBE_2 = 4'b1011;
  localparam logic [NUM_COLS-1:0] COL_STROBE_3 = 4'b0111;

  // Key index = col*4 + row.
  localparam logic [KEY_IDX_W-1:0] KEY_UP    = 4'd1;
  localparam logic [KEY_IDX_W-1:0] KEY_LEFT  = 4'd4;
  localparam logic [KEY_IDX_W-1:0] KEY_DOWN  = 4'd9;
  localparam logic [KEY_IDX_W-1:0] KEY_RIGHT = 4'd6;
  localparam logic [KEY_IDX_W-1:0] KEY_START = 4'd15;

  typedef logic [NUM_KEYS-1:0] key_map_t;

  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [1:0] idx);
    logic [NUM_COLS-1:0] s;
    case (idx)
      2'd0:    s = COL_STROBE_0;
      2'd1:    s = COL_STROBE_1;
      2'd2:    s = COL_STROBE_2;
      default: s = COL_STROBE_3;
    endcase
    return s;
  endfunction

  function automatic logic is_single_key(input key_map_t m);
    return (m != '0) && ((m & (m - key_map_t'(1))) == '0);
  endfunction

  function automatic logic [KEY_IDX_W-1:0] key_index(input key_map_t m);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (m[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key report, as seen by the scanner (master) and its user (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0]  ROW;
  logic [NUM_COLS-1:0]  COL;
  logic [KEY_IDX_W-1:0] key_code;
  logic                 key_valid;
  logic                 key_held;
  key_map_t             key_map;

  modport master (
    input  ROW,
    output COL,
    output key_code,
    output key_valid,
    output key_held,
    output key_map
  );

  modport slave (
    output ROW,
    input  COL,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  key_map
  );

endinterface

// File: rtl/keypad_debounce.sv
// Whole-map debouncer: loads key_map after DEBOUNCE_SWEEPS identical sweeps, pulses key_valid
// for a fresh single-key press out of an all-released map; acts one cycle after sweep_done.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SWEEPS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sweep_done,
  input  key_map_t             raw,
  output key_map_t             key_map,
  output logic                 key_held,
  output logic                 key_valid,
  output logic [KEY_IDX_W-1:0] key_code
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SWEEPS);

  key_map_t   prev_raw;
  logic [3:0] stable_cnt;
  logic [3:0] cnt_next;
  logic       load;
  logic       press;

  always_comb begin
    cnt_next = 4'd0;
    if (raw == prev_raw) begin
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 4'd1;
    end
    // Only the transition into the threshold loads; a saturated count never reloads.
    load  = sweep_done && (cnt_next == CNT_MAX) && (stable_cnt != CNT_MAX);
    press = load && (key_map == '0) && is_single_key(raw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw   <= '0;
      stable_cnt <= 4'd0;
      key_map    <= '0;
      key_held   <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
    end else begin
      key_valid <= press;
      if (sweep_done) begin
        prev_raw   <= raw;
        stable_cnt <= cnt_next;
      end
      if (load) begin
        key_map  <= raw;
        key_held <= (raw != '0);
      end
      if (press) begin
        key_code <= key_index(raw);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column strobe rotation, 2-flop row sync, raw snapshot per sweep.
// A press stable on the pins is reported within (DEBOUNCE_SWEEPS+2)*4*SCAN_HOLD+2 cycles.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_HOLD       = 3,
  parameter int DEBOUNCE_SWEEPS = 2
) (
  input  logic             clk1khz,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);

  localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [1:0]          col_idx;
  logic [NUM_COLS-1:0] col_q;
  key_map_t            raw;
  logic                sweep_done;
  logic                sample;

  // Sampling on the last hold cycle lets the strobe propagate through both sync flops first.
  assign sample = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk1khz or negedge rst_n) begin
    if (!rst_n) begin
      row_meta   <= '1;
      row_sync   <= '1;
      hold_cnt   <= '0;
      col_idx    <= 2'd0;
      col_q      <= COL_STROBE_0;
      raw        <= '0;
      sweep_done <= 1'b0;
    end else begin
      row_meta   <= kp.ROW;
      row_sync   <= row_meta;
      sweep_done <= sample && (col_idx == 2'd3);
      if (sample) begin
        hold_cnt                            <= '0;
        raw[col_idx*NUM_ROWS +: NUM_ROWS]   <= ~row_sync;
        col_idx                             <= col_idx + 2'd1;
        col_q                               <= col_strobe(col_idx + 2'd1);
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign kp.COL = col_q;

  keypad_debounce #(
    .DEBOUNCE_SWEEPS (DEBOUNCE_SWEEPS)
  ) u_debounce (
    .clk        (clk1khz),
    .rst_n      (rst_n),
    .sweep_done (sweep_done),
    .raw        (raw),
    .key_map    (kp.key_map),
    .key_held   (kp.key_held),
    .key_valid  (kp.key_valid),
    .key_code   (kp.key_code)
  );

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad (Snake direction/control keys) by strobing columns one at a time. It reads the rows back, debounces whole-keypad snapshots, and reports new single-key presses as a code plus a one-cycle pulse.
- This is the input-side counterpart of the 4-digit display multiplexer. It uses the same 1 kHz scan clock and the same active-low one-hot strobe rotation.

Parameters:
- SCAN_HOLD, 3, clock cycles each column stays driven; minimum 3 (2-flop row sync plus 1 settle).
- DEBOUNCE_SWEEPS, 2, consecutive identical full sweeps required before the debounced map updates; range 1..15.

Ports:
- clk1khz  in   1   scan clock, all logic on posedge.
- rst_n    in   1   asynchronous active-low reset.
- ROW      in   4   keypad rows, active-low (pulled up externally); asynchronous to clk1khz.
- COL      out  4   column strobes, active-low one-hot.
- key_code out  4   index of last newly pressed key = col*4 + row.
- key_valid out 1   one-cycle pulse when key_code is updated.
- key_held out  1   1 while the debounced map is nonzero.
- key_map  out  16  debounced pressed-key map; bit col*4+row set = pressed.

Behaviour:
- Interface (already decided): one clock, clk1khz; reset rst_n is asynchronous and active-low.
- Reset values:
  - COL=4'b1110, key_code=0, key_valid=0, key_held=0, key_map=0.
  - hold counter=0, column index=0, raw map=0, previous raw map=0, stable count=0.
  - row sync flops=4'b1111.
- Row input: two-flop synchronizer on ROW, then inverted (1 = pressed).
- Column scan:
  - Hold counter runs 0..SCAN_HOLD-1.
  - At count SCAN_HOLD-1, the synchronized rows are stored into raw[col*4 +: 4] and the column advances.
  - COL order: 1110 (col0) -> 1101 -> 1011 -> 0111 -> 1110. Column index wraps 3->0.
  - One sweep = 4*SCAN_HOLD cycles (12 at defaults).
- Sweep evaluation: one cycle after col3 is sampled, a sweep_done strobe fires.
  - If raw == prev_raw, stable_cnt increments, saturating at DEBOUNCE_SWEEPS; otherwise stable_cnt clears to 0.
  - prev_raw <= raw.
  - key_map <= raw only on the cycle stable_cnt transitions into DEBOUNCE_SWEEPS. A saturated count does not reload.
- Press reporting: key_valid pulses for exactly one cycle coincident with a key_map update, only when:
  - the old key_map == 0, and
  - the new key_map has exactly one bit set.
  - On that pulse, key_code <= index of the set bit. key_code holds between pulses.
- key_held = (key_map != 0), registered together with key_map.
- Boundary cases:
  - Multiple keys pressed: key_map reflects all of them; no pulse; key_code unchanged.
  - Rollover A->B without an all-released debounced state: no pulse for B.
  - Release: key_map clears after debounce; no pulse.
  - Bounce across a sweep boundary: resets stable_cnt; no partial update.
- Latency: a press stable on the pins is reported within (DEBOUNCE_SWEEPS+2)*4*SCAN_HOLD + 2 cycles, i.e. 50 at defaults.
- Reset mid-operation: all state clears immediately, without waiting for a clock edge. The scan restarts at col0 after rst_n deasserts. A key held through reset is re-reported as a new press after debounce.

Decomposition:
- Shared package keypad_pkg:
  - COL strobe constants 4'b1110/1101/1011/0111, shared with the display mux AN encoding.
  - KEY_IDX_W=4, NUM_COLS=4, NUM_ROWS=4.
  - Named key-index constants for the Snake up/down/left/right/start keys.
- One sub-module: keypad_debounce. It contains the sweep compare, stable_cnt, key_map load, and single-key detect/encode. The top keeps the synchronizer, hold counter and column rotation.

Test Plan:
- Reset and scan: hold rst_n low -> COL=1110, all outputs 0. After release, COL steps 1110x3, 1101x3, 1011x3, 0111x3 and repeats with period 12.
- Single press, key (col2,row1): ROW[1] driven low only while COL=1011, held 80 cycles -> exactly one key_valid, key_code=9, key_map=16'h0200, key_held=1, pulse within 50 cycles. Release -> key_map=0 and key_held=0 after debounce, no pulse.
- Bounce, key (col0,row0): ROW[0] toggled every 5 cycles for 40 cycles, then steady -> exactly one pulse, key_code=0, and none during the bounce window.
- Two keys, (col1,row0) and (col3,row3) -> key_map=16'h8010, key_held=1, no key_valid, key_code keeps its previous value.
- Rollover: press key 5, then add key 6, then drop key 5 without a full release -> only one pulse (code 5). Release all, then press key 6 -> pulse with code 6.
- Reset mid-press: key 9 held and reported, then pulse rst_n low for 1 cycle -> outputs clear at once. With key 9 still held -> new pulse with code 9 within 50 cycles.
